// File: rtl/axis_emu_multi.sv
// axis_emu_multi: N-channel analog-axis emulator (wheel / pedal / lever).
// Each channel turns buttons, a signed stick or an unsigned paddle into a
// WIDTH-bit position. On every vsync rising edge one sweep walks the channels
// in order through a single shared step/clamp datapath, one channel per clock.
// Build option: define AXIS_EMU_DEADZONE_EN to give the analog modes a dead
// zone of +/-DEADZONE around CENTER.

// Shared per-channel step: next position plus hold/direction state.
module axis_emu_dp #(
  parameter int WIDTH       = 8,
  parameter int CENTER      = 'h70,
  parameter int VMIN        = 'h00,
  parameter int VMAX        = 'hFF,
  parameter int STEP_MAX    = 8,
  parameter int RETURN_STEP = 4,
  parameter int DEADZONE    = 4
) (
  input  logic [1:0]       mode,
  input  logic             plus,
  input  logic             minus,
  input  logic [7:0]       ana,
  input  logic [WIDTH-1:0] cur,
  input  logic [3:0]       hold,
  input  logic             dneg,
  output logic [WIDTH-1:0] nxt,
  output logic [3:0]       nhold,
  output logic             ndneg
);
  // Two spare bits so a step past either rail never wraps before the clamp.
  localparam int SW = WIDTH + 2;
  typedef logic signed [SW-1:0] sw_t;

  localparam sw_t        C_S    = sw_t'(CENTER);
  localparam sw_t        VMIN_S = sw_t'(VMIN);
  localparam sw_t        VMAX_S = sw_t'(VMAX);
  localparam sw_t        RS_S   = sw_t'(RETURN_STEP);
  localparam logic [3:0] SMAX   = 4'(STEP_MAX);
`ifdef AXIS_EMU_DEADZONE_EN
  localparam sw_t        DZ_S   = sw_t'(DEADZONE);
`else
  // Zero-width dead zone: only offset 0 snaps to CENTER, which is an identity.
  localparam sw_t        DZ_S   = sw_t'(DEADZONE * 0);
`endif

  logic       up, dn;
  logic [7:0] ana_m;
  logic [3:0] st4;
  sw_t        cur_s, off, step, sum, sum_c;

  // Mode-dependent next position, then saturate to [VMIN, VMAX].
  always_comb begin
    up    = plus & ~minus;
    dn    = minus & ~plus;
    ana_m = mode[0] ? (ana ^ 8'h80) : ana;   // paddle: re-centre unsigned sample
    cur_s = sw_t'({2'b00, cur});
    off   = sw_t'($signed(ana_m)) >>> 1;
    if (off >= -DZ_S && off <= DZ_S) off = '0;
    nhold = '0;
    ndneg = 1'b0;
    st4   = '0;
    step  = '0;
    sum   = cur_s;
    if (mode[1]) begin
      sum = C_S + off;
    end else if (up | dn) begin
      // hold counts consecutive frames in one direction, this frame included
      if (hold != 4'd0 && dneg == dn) nhold = (hold == 4'hF) ? hold : hold + 4'd1;
      else                            nhold = 4'd1;
      ndneg = dn;
      st4   = 4'd1 + {1'b0, nhold[3:1]};
      if (st4 > SMAX) st4 = SMAX;
      step  = sw_t'(st4);
      sum   = dn ? cur_s - step : cur_s + step;
    end else if (!mode[0]) begin
      // self-centring: approach CENTER, landing on it exactly
      if (cur_s > C_S)      sum = (cur_s - RS_S < C_S) ? C_S : cur_s - RS_S;
      else if (cur_s < C_S) sum = (cur_s + RS_S > C_S) ? C_S : cur_s + RS_S;
    end
    if (sum < VMIN_S)      sum_c = VMIN_S;
    else if (sum > VMAX_S) sum_c = VMAX_S;
    else                   sum_c = sum;
    nxt = WIDTH'(sum_c);
  end
endmodule

module axis_emu_multi #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int CENTER      = 'h70,
  parameter int VMIN        = 'h00,
  parameter int VMAX        = 'hFF,
  parameter int STEP_MAX    = 8,
  parameter int RETURN_STEP = 4,
  parameter int DEADZONE    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vsync,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [8*CHANNELS-1:0]     ana_in,
  output logic [WIDTH*CHANNELS-1:0] value,
  output logic                      busy
);
  localparam int            IW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                     state, state_n;
  logic [IW-1:0]              idx, idx_n;
  logic                       pend, pend_n;
  logic                       vsync_d, tick, upd;
  logic [CHANNELS-1:0][1:0]   mode_a;
  logic [CHANNELS-1:0][7:0]   ana_a;
  logic [WIDTH-1:0]           val_q  [CHANNELS];
  logic [3:0]                 hold_q [CHANNELS];
  logic                       dneg_q [CHANNELS];
  logic [WIDTH-1:0]           dp_val;
  logic [3:0]                 dp_hold;
  logic                       dp_dneg;

  assign mode_a = mode;
  assign ana_a  = ana_in;
  assign tick   = vsync & ~vsync_d;
  assign busy   = (state == S_SWEEP);

  // Sweep control, vsync edge detector and one-deep pending tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      pend    <= 1'b0;
      vsync_d <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pend    <= pend_n;
      vsync_d <= vsync;
    end
  end

  // Next sweep state; a tick on the last sweep cycle restarts directly.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    pend_n  = pend;
    upd     = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_n = S_SWEEP;
          idx_n   = '0;
        end
      end
      S_SWEEP: begin
        upd = 1'b1;
        if (idx == LAST) begin
          if (pend || tick) begin
            idx_n  = '0;
            pend_n = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          idx_n = idx + IW'(1);
          if (tick) pend_n = 1'b1;   // a second tick while pending is dropped
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  axis_emu_dp #(
    .WIDTH(WIDTH), .CENTER(CENTER), .VMIN(VMIN), .VMAX(VMAX),
    .STEP_MAX(STEP_MAX), .RETURN_STEP(RETURN_STEP), .DEADZONE(DEADZONE)
  ) u_dp (
    .mode  (mode_a[idx]),
    .plus  (plus[idx]),
    .minus (minus[idx]),
    .ana   (ana_a[idx]),
    .cur   (val_q[idx]),
    .hold  (hold_q[idx]),
    .dneg  (dneg_q[idx]),
    .nxt   (dp_val),
    .nhold (dp_hold),
    .ndneg (dp_dneg)
  );

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    // Channel k state: written only on its own sweep cycle.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        val_q[k]  <= WIDTH'(CENTER);
        hold_q[k] <= '0;
        dneg_q[k] <= 1'b0;
      end else if (upd && idx == IW'(k)) begin
        val_q[k]  <= dp_val;
        hold_q[k] <= dp_hold;
        dneg_q[k] <= dp_dneg;
      end
    end
    assign value[k*WIDTH +: WIDTH] = val_q[k];
  end
endmodule

// File: tb/tb_axis_emu_multi.sv
// Bench for axis_emu_multi: directed scenarios plus random frames against a
// frame-level integer model of the axis rules.
module tb_axis_emu_multi;
  localparam int CH = 2, W = 8, CENTER = 'h70, VMIN = 0, VMAX = 'hFF;
  localparam int STEP_MAX = 8, RS = 4, DZ = 4;

  logic                clk = 1'b0, reset_n = 1'b0, vsync = 1'b0;
  logic [2*CH-1:0]     mode = '0;
  logic [CH-1:0]       plus = '0, minus = '0;
  logic [8*CH-1:0]     ana_in = '0;
  logic [W*CH-1:0]     value;
  logic                busy;

  int n_cmp = 0, n_err = 0;
  int mval[CH], mhold[CH], mdir[CH];

  always #5 clk = ~clk;

  axis_emu_multi #(
    .CHANNELS(CH), .WIDTH(W), .CENTER(CENTER), .VMIN(VMIN), .VMAX(VMAX),
    .STEP_MAX(STEP_MAX), .RETURN_STEP(RS), .DEADZONE(DZ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .mode(mode), .plus(plus),
    .minus(minus), .ana_in(ana_in), .value(value), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_ch(input int c, input logic [1:0] md, input logic p,
                        input logic m, input logic [7:0] a);
    mode[c*2 +: 2]  = md;
    plus[c]         = p;
    minus[c]        = m;
    ana_in[c*8 +: 8] = a;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      mval[c] = CENTER; mhold[c] = 0; mdir[c] = 0;
    end
  endfunction

  // One frame of the axis rules for every channel, using current inputs.
  function automatic void model_frame();
    for (int c = 0; c < CH; c++) begin
      int md, s, off, v, d, st;
      md = int'(mode[c*2 +: 2]);
      v  = mval[c];
      if (md >= 2) begin
        s = int'(ana_in[c*8 +: 8]);
        if (md == 3) s = s ^ 128;
        if (s >= 128) s = s - 256;
        off = s >>> 1;
`ifdef AXIS_EMU_DEADZONE_EN
        if (off >= -DZ && off <= DZ) off = 0;
`endif
        v = CENTER + off;
        mhold[c] = 0; mdir[c] = 0;
      end else begin
        d = (plus[c] && !minus[c]) ? 1 : ((minus[c] && !plus[c]) ? -1 : 0);
        if (d == 0) begin
          mhold[c] = 0;
          if (md == 0) begin
            if (v > CENTER)      v = (v - RS < CENTER) ? CENTER : v - RS;
            else if (v < CENTER) v = (v + RS > CENTER) ? CENTER : v + RS;
          end
        end else begin
          if (d == mdir[c] && mhold[c] > 0) mhold[c] = (mhold[c] < 15) ? mhold[c] + 1 : 15;
          else                              mhold[c] = 1;
          st = 1 + mhold[c] / 2;
          if (st > STEP_MAX) st = STEP_MAX;
          v = v + d * st;
        end
        mdir[c] = d;
      end
      if (v < VMIN) v = VMIN;
      if (v > VMAX) v = VMAX;
      mval[c] = v;
    end
  endfunction

  // Raise vsync for one cycle, wait (bounded) for the sweep, advance the model.
  task automatic do_frame();
    int n;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_err++;
      $display("FAIL frame_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
    model_frame();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (value[c*W +: W] !== 8'h70) begin
        n_err++; $display("FAIL reset_value ch%0d: got %h want 70", c, value[c*W +: W]);
      end
    end
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < CH; c++)
      set_ch(c, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 8'($urandom));
    repeat (20) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL idle_busy: got %b want 0", busy);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (value[c*W +: W] !== 8'h70) begin
        n_err++; $display("FAIL idle_value ch%0d: got %h want 70", c, value[c*W +: W]);
      end
    end
    for (int c = 0; c < CH; c++) set_ch(c, 2'b01, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_self_centre();
    set_ch(0, 2'b00, 1'b1, 1'b0, 8'h00);
    set_ch(1, 2'b01, 1'b0, 1'b0, 8'h00);
    for (int f = 0; f < 10; f++) begin
      do_frame();
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*W +: W] !== W'(mval[c])) begin
          n_err++; $display("FAIL centre_press f%0d ch%0d: got %h want %h", f, c, value[c*W +: W], W'(mval[c]));
        end
      end
    end
    n_cmp++;
    if (value[7:0] !== 8'h93) begin
      n_err++; $display("FAIL centre_peak: got %h want 93", value[7:0]);
    end
    set_ch(0, 2'b00, 1'b0, 1'b0, 8'h00);
    for (int f = 0; f < 10; f++) begin
      do_frame();
      n_cmp++;
      if (value[7:0] !== W'(mval[0])) begin
        n_err++; $display("FAIL centre_return f%0d: got %h want %h", f, value[7:0], W'(mval[0]));
      end
    end
    n_cmp++;
    if (value[7:0] !== 8'h70) begin
      n_err++; $display("FAIL centre_land: got %h want 70", value[7:0]);
    end
  endtask

  task automatic test_hold_sat();
    set_ch(1, 2'b01, 1'b0, 1'b1, 8'h00);
    for (int f = 0; f < 40; f++) begin
      do_frame();
      n_cmp++;
      if (value[15:8] !== W'(mval[1])) begin
        n_err++; $display("FAIL hold_minus f%0d: got %h want %h", f, value[15:8], W'(mval[1]));
      end
    end
    n_cmp++;
    if (value[15:8] !== 8'h00) begin
      n_err++; $display("FAIL hold_floor: got %h want 00", value[15:8]);
    end
    set_ch(1, 2'b01, 1'b0, 1'b0, 8'h00);
    repeat (3) do_frame();
    set_ch(1, 2'b01, 1'b1, 1'b1, 8'h00);
    repeat (3) do_frame();
    n_cmp++;
    if (value[15:8] !== 8'h00) begin
      n_err++; $display("FAIL hold_release_both: got %h want 00", value[15:8]);
    end
  endtask

  task automatic test_analog();
    logic [1:0] md_t [5];
    logic [7:0] a_t  [5];
    logic [7:0] e_t  [5];
    md_t = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    a_t  = '{8'h80, 8'h7F, 8'h00, 8'h80, 8'h06};
`ifdef AXIS_EMU_DEADZONE_EN
    e_t  = '{8'h30, 8'hAF, 8'h30, 8'h70, 8'h70};
`else
    e_t  = '{8'h30, 8'hAF, 8'h30, 8'h70, 8'h73};
`endif
    for (int i = 0; i < 5; i++) begin
      set_ch(0, md_t[i], 1'b0, 1'b0, a_t[i]);
      do_frame();
      n_cmp++;
      if (value[7:0] !== e_t[i]) begin
        n_err++; $display("FAIL analog_%0d mode %b ana %h: got %h want %h", i, md_t[i], a_t[i], value[7:0], e_t[i]);
      end
    end
    // switching back to digital continues from the analog position
    set_ch(0, 2'b01, 1'b1, 1'b0, 8'h00);
    do_frame();
    n_cmp++;
    if (value[7:0] !== e_t[4] + 8'h01) begin
      n_err++; $display("FAIL analog_to_digital: got %h want %h", value[7:0], e_t[4] + 8'h01);
    end
  endtask

  task automatic test_sweep_timing();
    int o0, o1;
    set_ch(0, 2'b10, 1'b0, 1'b0, 8'h20);
    set_ch(1, 2'b11, 1'b0, 1'b0, 8'hC0);
    o0 = mval[0]; o1 = mval[1];
    model_frame();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || value[7:0] !== W'(o0) || value[15:8] !== W'(o1)) begin
      n_err++; $display("FAIL sweep_c0: busy %b v %h/%h want 1 %h/%h", busy, value[7:0], value[15:8], W'(o0), W'(o1));
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || value[7:0] !== W'(mval[0]) || value[15:8] !== W'(o1)) begin
      n_err++; $display("FAIL sweep_c1: busy %b v %h/%h want 1 %h/%h", busy, value[7:0], value[15:8], W'(mval[0]), W'(o1));
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || value[7:0] !== W'(mval[0]) || value[15:8] !== W'(mval[1])) begin
      n_err++; $display("FAIL sweep_c2: busy %b v %h/%h want 0 %h/%h", busy, value[7:0], value[15:8], W'(mval[0]), W'(mval[1]));
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    set_ch(0, 2'b01, 1'b1, 1'b0, 8'h00);
    set_ch(1, 2'b01, 1'b1, 1'b0, 8'h00);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    cnt = int'(busy);
    @(negedge clk) vsync = 1'b1;
    cnt += int'(busy);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) vsync = 1'b0;
      cnt += int'(busy);
    end
    model_frame();
    model_frame();
    n_cmp++;
    if (cnt !== 2 * CH) begin
      n_err++; $display("FAIL b2b_busy_cycles: got %0d want %0d", cnt, 2 * CH);
    end
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (value[c*W +: W] !== W'(mval[c])) begin
        n_err++; $display("FAIL b2b_value ch%0d: got %h want %h", c, value[c*W +: W], W'(mval[c]));
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      for (int c = 0; c < CH; c++) begin
        logic [1:0] md;
        md = mode[c*2 +: 2];
        if ($urandom_range(0, 3) == 0) md = 2'($urandom_range(0, 3));
        set_ch(c, md, 1'($urandom), 1'($urandom), 8'($urandom));
      end
      do_frame();
      for (int c = 0; c < CH; c++) begin
        n_cmp++;
        if (value[c*W +: W] !== W'(mval[c])) begin
          n_err++; $display("FAIL random f%0d ch%0d: got %h want %h", f, c, value[c*W +: W], W'(mval[c]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    set_ch(0, 2'b10, 1'b0, 1'b0, 8'h40);
    set_ch(1, 2'b01, 1'b1, 1'b0, 8'h00);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || value !== {CH{8'h70}}) begin
      n_err++; $display("FAIL midsweep_reset: busy %b value %h want 0 %h", busy, value, {CH{8'h70}});
    end
    @(negedge clk) reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || value !== {CH{8'h70}}) begin
      n_err++; $display("FAIL midsweep_discard: busy %b value %h want 0 %h", busy, value, {CH{8'h70}});
    end
    set_ch(0, 2'b10, 1'b0, 1'b0, 8'h00);
    do_frame();
    for (int c = 0; c < CH; c++) begin
      n_cmp++;
      if (value[c*W +: W] !== W'(mval[c])) begin
        n_err++; $display("FAIL midsweep_after ch%0d: got %h want %h", c, value[c*W +: W], W'(mval[c]));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_self_centre();
    test_hold_sat();
    test_analog();
    test_sweep_timing();
    test_back_to_back();
    test_random();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
